// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive controllers:
//   - DATA_BITS     : payload width of one UART character (8)
//   - uart_state_e  : frame FSM state encoding (IDLE/START/DATA/PARITY/STOP)
//   - parity_bit()  : parity bit for a character, even or odd
// No ports; import with `import uart_pkg::*;`.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS = 8;

  // Three encodings (5..7) are unused; both controllers recover from them to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity makes the total count of ones (data + parity) even, so the
  // parity bit is the XOR of the data. Odd parity is its complement.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                      input logic                 odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// -----------------------------------------------------------------------------
// uart_baud_counter
// Counts clk cycles within one UART bit period. While en_i is high the
// internal clk_cnt runs 0..CLKS_PER_BIT-1 and bit_end_o is high on the last
// cycle of each bit, so the owning FSM advances on the edge that ends the bit.
// While en_i is low the count is held at 0, so the first cycle after enabling
// is always cycle 0 of a fresh bit.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per bit, must be >= 2
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous, active-low reset
//   en_i       in   count enable (FSM is inside a frame)
//   bit_end_o  out  last cycle of the current bit period
// -----------------------------------------------------------------------------
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  output logic bit_end_o
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] clk_cnt_q;

  assign bit_end_o = en_i && (clk_cnt_q == CNT_LAST);

  // Wrapping exactly at CNT_LAST keeps the count inside 0..CLKS_PER_BIT-1
  // even when CLKS_PER_BIT is not a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: state registers use non-blocking (<=) so every flop samples the
      // pre-edge values; blocking here would create order-dependent races.
      clk_cnt_q <= '0;
    end else if (!en_i || bit_end_o) begin
      clk_cnt_q <= '0;
    end else begin
      clk_cnt_q <= clk_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_controller.sv
// -----------------------------------------------------------------------------
// uart_tx_controller
// Serialises bytes onto a UART line: start bit (0), 8 data bits LSB-first,
// optional parity bit, then 1 or 2 stop bits (1). The line idles high.
// A one-entry holding register sits between the byte source and the shift
// register, so the next byte can be accepted while the current frame is on
// the line and frames can follow each other with no idle gap.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per line bit, must be >= 2
//   PARITY_EN     1 = insert a parity bit after D7
//   PARITY_ODD    0 = even parity, 1 = odd parity (ignored if PARITY_EN = 0)
//   STOP_BITS     number of stop bits, 1 or 2
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous, active-low reset
//   i_Tx_Valid   in   byte offered on i_Tx_Byte
//   i_Tx_Byte    in   byte to transmit
//   o_Tx_Ready   out  holding register empty; accept = i_Tx_Valid & o_Tx_Ready
//   o_Tx_Serial  out  serial line, registered, idle high
//   o_Tx_Busy    out  FSM is inside a frame (not IDLE)
//   o_Tx_Done    out  one-cycle pulse after the last stop bit of each frame
// -----------------------------------------------------------------------------
module uart_tx_controller
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_Tx_Valid,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Busy,
  output logic                 o_Tx_Done
);

  localparam logic [2:0] LAST_DATA_IDX = 3'(DATA_BITS - 1);
  // stop_cnt value in the final stop bit: 0 with one stop bit, 1 with two.
  localparam logic       STOP_LAST     = (STOP_BITS == 2);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [2:0]           bit_idx_q;
  logic                 stop_cnt_q;
  logic                 serial_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] hold_byte_q, hold_byte_d;

  // ---------------------------------------------------------------------------
  // Bit timing
  // ---------------------------------------------------------------------------
  logic in_frame;
  logic bit_end;

  // Decoded from the state itself rather than busy_q so an illegal encoding
  // never runs the counter.
  assign in_frame = (state_q == ST_START) || (state_q == ST_DATA) ||
                    (state_q == ST_PARITY) || (state_q == ST_STOP);

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .reset_n   (reset_n),
    .en_i      (in_frame),
    .bit_end_o (bit_end)
  );

  // ---------------------------------------------------------------------------
  // Holding register
  // ---------------------------------------------------------------------------
  logic last_stop_end;
  logic take_byte;
  logic accept;

  assign last_stop_end = (state_q == ST_STOP) && bit_end && (stop_cnt_q == STOP_LAST);

  // The FSM pulls the held byte either from IDLE or straight out of the last
  // stop bit (back-to-back). Both cases must agree with the FSM below.
  assign take_byte = hold_full_q && ((state_q == ST_IDLE) || last_stop_end);

  // Accept only into an empty register: a full register is never overwritten,
  // and a byte cannot enter in the same cycle the old one leaves.
  assign accept = i_Tx_Valid && !hold_full_q;

  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    hold_full_d = hold_full_q;
    hold_byte_d = hold_byte_q;
    if (take_byte) begin
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_full_d = 1'b1;
      hold_byte_d = i_Tx_Byte;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full_q <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
    end
  end

  // NOTE: the held byte is a data register with no reset: it is only ever read
  // while hold_full_q is set, and hold_full_q is reset.
  always_ff @(posedge clk) begin
    hold_byte_q <= hold_byte_d;
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // The line value for a bit is registered on the edge that enters the bit,
  // so o_Tx_Serial changes exactly at bit boundaries and holds for a full
  // CLKS_PER_BIT cycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      serial_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          serial_q <= 1'b1;
          busy_q   <= 1'b0;
          if (take_byte) begin
            state_q  <= ST_START;
            shift_q  <= hold_byte_q;
            serial_q <= 1'b0;
            busy_q   <= 1'b1;
          end
        end

        ST_START: begin
          if (bit_end) begin
            state_q   <= ST_DATA;
            bit_idx_q <= '0;
            serial_q  <= shift_q[0];
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx_q == LAST_DATA_IDX) begin
              if (PARITY_EN != 0) begin
                state_q  <= ST_PARITY;
                serial_q <= parity_bit(shift_q, PARITY_ODD != 0);
              end else begin
                state_q    <= ST_STOP;
                stop_cnt_q <= 1'b0;
                serial_q   <= 1'b1;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              serial_q  <= shift_q[bit_idx_q + 3'd1];
            end
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            state_q    <= ST_STOP;
            stop_cnt_q <= 1'b0;
            serial_q   <= 1'b1;
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            if (stop_cnt_q == STOP_LAST) begin
              done_q <= 1'b1;
              if (take_byte) begin
                // Back-to-back: the next start bit follows with no idle cycle.
                state_q  <= ST_START;
                shift_q  <= hold_byte_q;
                serial_q <= 1'b0;
              end else begin
                state_q  <= ST_IDLE;
                busy_q   <= 1'b0;
                serial_q <= 1'b1;
              end
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          serial_q <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_Tx_Ready  = !hold_full_q;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Busy   = busy_q;
  assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_controller
// Four transmitters with CLKS_PER_BIT = 4 run side by side:
//   cfg0: no parity, 1 stop    cfg1: even parity, 1 stop
//   cfg2: odd parity, 1 stop   cfg3: no parity, 2 stops
// Each has a driver that offers directed then random bytes and, on every
// accepted byte, pushes the expected frame (data, accept edge, start edge)
// into a queue. A monitor samples all outputs on every falling edge and
// compares them with the line the queued frames describe; a frame is popped
// when its Done pulse is due.
// Frame timing model (edges counted from time 0):
//   start = (accept edge < end edge of previous frame) ? previous end : accept + 1
//   end   = start + (1 + 8 + parity + stops) * CLKS_PER_BIT
// -----------------------------------------------------------------------------
module tb_uart_tx_controller;

  localparam int N = 4;

  typedef struct {
    logic [7:0] data;
    longint     acc;
    longint     start;
  } frame_t;

  typedef struct {
    logic [7:0] data;
    int         gap;   // cycles before offering; 0 = keep valid asserted; -1 = offer to land on frame end
  } stim_t;

  logic   clk     = 1'b0;
  logic   reset_n = 1'b0;
  longint cyc     = 0;
  int     phase   = 0;
  int     checks  = 0;
  int     errors  = 0;

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input int inst, input string what, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got %0d expected %0d (cycle %0d)", inst, what, act, exp, cyc);
    end
  endtask

  // Line level of bit idx of a frame, straight from the frame format.
  function automatic logic exp_bit(input logic [7:0] d, input int pen, input int podd, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (pen != 0 && idx == 9) return (($countones(d) % 2) == 1) ^ (podd != 0);
    return 1'b1;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int PEN   = (g == 1 || g == 2) ? 1 : 0;
    localparam int PODD  = (g == 2) ? 1 : 0;
    localparam int STOPB = (g == 3) ? 2 : 1;
    localparam int FLEN  = (9 + PEN + STOPB) * N;

    logic       valid;
    logic [7:0] tx_byte;
    logic       ready, serial, busy, tx_done;
    frame_t     exp_q[$];
    stim_t      stim[$];
    longint     last_end;
    logic       done1, done2;

    uart_tx_controller #(
      .CLKS_PER_BIT (N),
      .PARITY_EN    (PEN),
      .PARITY_ODD   (PODD),
      .STOP_BITS    (STOPB)
    ) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_Tx_Valid  (valid),
      .i_Tx_Byte   (tx_byte),
      .o_Tx_Ready  (ready),
      .o_Tx_Serial (serial),
      .o_Tx_Busy   (busy),
      .o_Tx_Done   (tx_done)
    );

    // Called at a falling edge; returns at a falling edge.
    task automatic send(input logic [7:0] b, input int gap);
      int     waited;
      longint a, s;
      if (gap < 0) begin
        waited = 0;
        while (cyc + 1 < last_end && waited < 500) begin
          @(negedge clk);
          waited++;
        end
      end else begin
        repeat (gap) @(negedge clk);
      end
      valid   = 1'b1;
      tx_byte = b;
      waited  = 0;
      while (!ready && waited < 500) begin
        @(negedge clk);
        waited++;
      end
      if (!ready) begin
        check(g, "accept_timeout", int'(ready), 1);
      end else begin
        a = cyc + 1;
        s = (a < last_end) ? last_end : a + 1;
        exp_q.push_back('{b, a, s});
        last_end = s + FLEN;
        @(negedge clk);
      end
      valid = 1'b0;
    endtask

    initial begin : drv
      int r;
      valid    = 1'b0;
      tx_byte  = 8'h00;
      last_end = 0;
      done1    = 1'b0;
      done2    = 1'b0;
      case (g)
        0: begin
          stim.push_back('{8'hA5, 2});
          stim.push_back('{8'h3C, -1});
          stim.push_back('{8'hC3, 0});
          stim.push_back('{8'h5A, 0});
        end
        1, 2:    stim.push_back('{8'h07, 2});
        default: stim.push_back('{8'hFF, 2});
      endcase
      for (int k = 0; k < 25; k++) begin
        r = int'($urandom_range(0, 9));
        stim.push_back('{8'($urandom), (r < 3) ? 0 : (r == 3) ? -1 : int'($urandom_range(1, 50))});
      end

      wait (phase == 1);
      foreach (stim[k]) send(stim[k].data, stim[k].gap);
      done1 = 1'b1;

      wait (phase == 2);
      send(8'h55, 0);

      wait (phase == 3);
      last_end = 0;
      send(8'h81, 2);
      done2 = 1'b1;
    end

    initial forever begin : mon
      logic e_ser, e_busy, e_done, e_ready;
      @(negedge clk);
      e_ser   = 1'b1;
      e_busy  = 1'b0;
      e_done  = 1'b0;
      e_ready = 1'b1;
      if (!reset_n) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() > 0 && cyc == exp_q[0].start + FLEN) begin
          e_done = 1'b1;
          void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && cyc >= exp_q[0].start && cyc < exp_q[0].start + FLEN) begin
          e_busy = 1'b1;
          e_ser  = exp_bit(exp_q[0].data, PEN, PODD, int'((cyc - exp_q[0].start) / N));
        end
        foreach (exp_q[k]) begin
          if (exp_q[k].acc <= cyc && cyc < exp_q[k].start) e_ready = 1'b0;
        end
      end
      check(g, "serial", int'(serial), int'(e_ser));
      check(g, "busy", int'(busy), int'(e_busy));
      check(g, "done", int'(tx_done), int'(e_done));
      check(g, "ready", int'(ready), int'(e_ready));
    end

    // Reset must act without waiting for a clock edge.
    initial forever begin : rst_chk
      @(negedge reset_n);
      #1;
      check(g, "rst_serial", int'(serial), 1);
      check(g, "rst_busy", int'(busy), 0);
      check(g, "rst_ready", int'(ready), 1);
      check(g, "rst_done", int'(tx_done), 0);
    end
  end

  function automatic logic all_idle(input int which);
    logic d0, d1, d2, d3;
    d0 = (which == 1) ? g_cfg[0].done1 : g_cfg[0].done2;
    d1 = (which == 1) ? g_cfg[1].done1 : g_cfg[1].done2;
    d2 = (which == 1) ? g_cfg[2].done1 : g_cfg[2].done2;
    d3 = (which == 1) ? g_cfg[3].done1 : g_cfg[3].done2;
    return d0 && d1 && d2 && d3 &&
           g_cfg[0].exp_q.size() == 0 && g_cfg[1].exp_q.size() == 0 &&
           g_cfg[2].exp_q.size() == 0 && g_cfg[3].exp_q.size() == 0;
  endfunction

  initial begin : main
    logic idle;

    // Reset, then 50 quiet cycles with no valid.
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (50) @(negedge clk);

    // Directed plus random traffic.
    phase = 1;
    idle  = 1'b0;
    for (int t = 0; t < 30000; t++) begin
      idle = all_idle(1);
      if (idle) break;
      @(negedge clk);
    end
    check(-1, "traffic_drained", int'(idle), 1);
    repeat (5) @(negedge clk);

    // 0x55 starts on all four; reset lands in D3 (bit 4: edges start+16..start+19).
    phase = 2;
    repeat (19) @(posedge clk);
    #3 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);

    // A clean 0x81 after the aborted frame.
    phase = 3;
    idle  = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      idle = all_idle(2);
      if (idle) break;
      @(negedge clk);
    end
    check(-1, "post_reset_drained", int'(idle), 1);
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
